// File: rtl/mul_pkg.sv
// Shared encodings for the sequential multiplier: operand modes and FSM states.
// Helper functions decode which operand is signed for a given mode.
package mul_pkg;

    localparam logic [1:0] MODE_UU = 2'b00;
    localparam logic [1:0] MODE_SS = 2'b01;
    localparam logic [1:0] MODE_SU = 2'b10;
    localparam logic [1:0] MODE_US = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic a_is_signed(input logic [1:0] m);
        return (m == MODE_SS) || (m == MODE_SU);
    endfunction

    function automatic logic b_is_signed(input logic [1:0] m);
        return (m == MODE_SS) || (m == MODE_US);
    endfunction

endpackage

// File: rtl/mul_seq_if.sv
// Operand/result handshake bundle for mul_seq.
// master: in_valid, a, b, mode, out_ready out; in_ready, out_valid, lo, hi, busy in.
interface mul_seq_if #(
    parameter int W = 32
);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         busy;

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, lo, hi, busy
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, lo, hi, busy
    );

endinterface

// File: rtl/mul_seq_dp.sv
// Shift-add datapath: accumulator, multiplicand/multiplier shifters, add/sub.
// Ports: clk, rst, load, step, a_i, b_i, mode_i in; last_o, acc_o out.
// MUL_SEQ_EARLY_EXIT_EN: raise last_o once remaining multiplier bits are zero.
module mul_seq_dp
    import mul_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    input  logic [1:0]     mode_i,
    output logic           last_o,
    output logic [2*W-1:0] acc_o
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
`ifdef MUL_SEQ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] mcand_q, mcand_d;
    logic [2*W-1:0] pp;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           bsgn_q, bsgn_d;
    logic           bneg_q, bneg_d;
    logic           full;
    logic           early;
    logic           sub;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        bsgn_d   = bsgn_q;
        bneg_d   = bneg_q;
        pp       = mplier_q[0] ? mcand_q : '0;
        full     = (cnt_q == CNT_LAST);
        // A negative signed b still needs its weight -2^(W-1) term.
        early    = !bneg_q && (mplier_q[W-1:1] == '0);
        last_o   = full || (EARLY && early);
        // Bit W-1 of a signed multiplier carries negative weight.
        sub      = bsgn_q && full;
        if (load) begin
            acc_d    = '0;
            mcand_d  = a_is_signed(mode_i) ? {{W{a_i[W-1]}}, a_i}
                                           : {{W{1'b0}}, a_i};
            mplier_d = b_i;
            cnt_d    = '0;
            bsgn_d   = b_is_signed(mode_i);
            bneg_d   = b_is_signed(mode_i) && b_i[W-1];
        end else if (step) begin
            acc_d    = sub ? (acc_q - pp) : (acc_q + pp);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            bsgn_q   <= 1'b0;
            bneg_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            bsgn_q   <= bsgn_d;
            bneg_q   <= bneg_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/mul_seq.sv
// Sequential W x W multiplier, modes uu/ss/su/us, one multiplier bit per cycle.
// Ports: clk, rst (async, active high), bus (mul_seq_if.slave).
// MUL_SEQ_EARLY_EXIT_EN: shorten RUN for small non-negative multipliers.
module mul_seq
    import mul_pkg::*;
#(
    parameter int W = 32
) (
    input  logic       clk,
    input  logic       rst,
    mul_seq_if.slave   bus
);

    state_e         state_q, state_d;
    logic           load;
    logic           step;
    logic           last;
    logic [2*W-1:0] acc;

    mul_seq_dp #(.W(W)) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .a_i    (bus.a),
        .b_i    (bus.b),
        .mode_i (bus.mode),
        .last_o (last),
        .acc_o  (acc)
    );

    always_comb begin
        state_d       = state_q;
        load          = 1'b0;
        step          = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                bus.busy = 1'b1;
                step     = 1'b1;
                if (last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Result is only exposed while it is being offered.
    assign bus.lo = bus.out_valid ? acc[W-1:0]   : '0;
    assign bus.hi = bus.out_valid ? acc[2*W-1:W] : '0;

endmodule

// File: tb/tb_mul_seq.sv
// Directed + random bench for mul_seq (W=32) with a result scoreboard.
// Works with or without MUL_SEQ_EARLY_EXIT_EN.
module tb_mul_seq;
    import mul_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul_seq_if #(.W(W)) bus ();

    mul_seq #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [63:0] sb[$];
    int total  = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        assert (got === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] m,
                                          input logic [31:0] av,
                                          input logic [31:0] bv);
        logic signed [63:0] ea, eb;
        ea = a_is_signed(m) ? {{32{av[31]}}, av} : {32'b0, av};
        eb = b_is_signed(m) ? {{32{bv[31]}}, bv} : {32'b0, bv};
        return ea * eb;
    endfunction

    function automatic int exp_lat(input logic [1:0] m,
                                   input logic [31:0] bv);
`ifdef MUL_SEQ_EARLY_EXIT_EN
        if (b_is_signed(m) && bv[31]) return 32;
        for (int i = 31; i >= 0; i--) begin
            if (bv[i]) return i + 1;
        end
        return 1;
`else
        return 32;
`endif
    endfunction

    task automatic do_op(input logic [1:0] m, input logic [31:0] av,
                         input logic [31:0] bv, input logic [63:0] exp,
                         input int hold, input bit poke);
        int n;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.a        = av;
        bus.b        = bv;
        bus.mode     = m;
        @(posedge clk);
        sb.push_back(exp);
        @(negedge clk);
        bus.in_valid = poke;
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.mode     = 2'($urandom);
        chk("run_busy_nready", {bus.busy, bus.in_ready}, 2'b10);
        chk("run_zero", {bus.hi, bus.lo}, 0);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("latency", n, exp_lat(m, bv));
        chk("product", {bus.hi, bus.lo}, sb.pop_front());
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_data", {bus.hi, bus.lo}, exp);
            chk("hold_nready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("done_nready", bus.in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("idle_flags", {bus.out_valid, bus.busy, bus.in_ready}, 3'b001);
        chk("idle_zero", {bus.hi, bus.lo}, 0);
    endtask

    initial begin
        bit          seen;
        logic [1:0]  m;
        logic [31:0] av, bv;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.mode      = MODE_UU;
        #1;
        chk("rst_flags", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
        chk("rst_zero", {bus.hi, bus.lo}, 0);
        bus.in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_no_accept", bus.busy, 0);

        do_op(MODE_UU, 32'd292, 32'd6785, 64'd1981220, 0, 0);
        do_op(MODE_SS, -32'sd12345678, 32'd87654321,
              -64'sd1082152022374638, 5, 1);
        do_op(MODE_SU, -32'sd20000000, 32'hFFFF_FFFF,
              -64'sd85899345900000000, 0, 0);
        do_op(MODE_US, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              -64'sd4294967295, 0, 0);
        do_op(MODE_UU, 32'd12345, 32'd1, 64'd12345, 0, 0);
        do_op(MODE_SS, 32'h8000_0000, 32'd0, 64'd0, 0, 0);
        do_op(MODE_SS, 32'h8000_0000, 32'h8000_0000,
              64'h4000_0000_0000_0000, 0, 0);

        // Reset in RUN cycle 10 must abort the operation.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 32'd777;
        bus.b        = 32'hF000_0001;
        bus.mode     = MODE_UU;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_flags", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
        chk("mid_rst_zero", {bus.hi, bus.lo}, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("rst_no_valid", seen, 0);
        do_op(MODE_US, 32'd100, -32'sd3, -64'sd300, 0, 0);

        for (int i = 0; i < 10; i++) begin
            m  = 2'($urandom);
            av = $urandom;
            bv = (i < 4) ? 32'($urandom_range(0, 300)) : $urandom;
            do_op(m, av, bv, model(m, av, bv), i % 2, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
